fsm_step_ctrl: RTL
==================

Name: fsm_step_ctrl

Overview:
Front-end stage that drives the 2-state Moore FSM core. It feeds that core's switch input (sw_in) and step-enable input (ctrl_in).
- Synchronises and debounces two raw board switches and a step push-button.
- Generates one-cycle step pulses, either one per button press (manual) or periodically (auto-run).
- Guarantees the switch value never changes in the same cycle a step pulse is issued.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates; legal range >= 2.
- RUN_DIV, 8: clock cycles between auto-run step pulses; legal range >= 2.
- CNT_W, 8: width of step_count.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- sw_raw, in, 2: raw switch levels, asynchronous.
- btn_raw, in, 1: raw step button, asynchronous, active-high.
- run_raw, in, 1: raw mode switch, asynchronous; 1 = auto-run, 0 = manual.
- sw_out, out, 2: debounced switch value; drives FSM sw_in.
- ctrl_out, out, 1: registered one-cycle step pulse; drives FSM ctrl_in.
- step_count, out, CNT_W: number of pulses issued; wraps modulo 2^CNT_W.
- mode, out, 1: current mode; 0 = MANUAL, 1 = RUN.

Behaviour:
- Reset (synchronous, active-high):
  - All synchroniser flops, debounce counters, debounced values and the divider clear to 0.
  - The pending flag clears to 0.
  - sw_out=0, ctrl_out=0, step_count=0, mode=0 (MANUAL).
  - Reset asserted mid-debounce or with a pulse pending discards that work; no pulse is issued after reset.
- Synchronisers: sw_raw[1:0], btn_raw and run_raw each pass through a 2-flop synchroniser.
- Debounce (applies to sw bit 0, sw bit 1 and btn, each independently):
  - Each input has its own counter.
  - At a rising edge where the synchronised value differs from the debounced value, the counter increments.
  - At a rising edge where they are equal, the counter clears.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced value takes the synchronised value and the counter clears.
  - Latency: raw held stable from edge 0 gives an updated debounced value after edge DEBOUNCE_CYCLES+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
- sw_out equals the debounced switch pair.
- mode equals synchronised run_raw (synchronised only, not debounced).
- State machine, two states:
  - MANUAL:
    - A step request is raised at the edge where debounced btn goes 0->1.
    - Holding the button does not repeat the request.
    - Release (1->0) raises nothing.
  - RUN:
    - The divider counts 0..RUN_DIV-1 and wraps.
    - A step request is raised at each edge where the divider wraps to 0.
    - Button presses are ignored.
    - The first request occurs RUN_DIV edges after entering RUN.
  - Transitions MANUAL<->RUN follow mode at each edge.
  - The divider clears on every transition.
  - A pending request survives a mode change.
- Pulse issue:
  - ctrl_out is 1 for exactly one cycle per issued step.
  - It is set at the edge where the request is raised, except as below.
  - Collision rule: if sw_out updates at the same edge a request is raised, the request sets pending. ctrl_out is then asserted at the next edge and pending clears.
  - Requests arriving while pending is set, or while ctrl_out=1, merge into the outstanding request. At most one pulse is outstanding.
  - ctrl_out is never 1 in the cycle immediately following an sw_out change.
- step_count increments by 1 at every edge where ctrl_out is set to 1, wrapping from 2^CNT_W-1 to 0.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=5, CNT_W=8):
1. Reset, then sw_raw=2'b10 held -> sw_out changes 00->10 after the 5th edge following the first sampling edge. ctrl_out stays 0 and step_count=0.
2. sw_raw[0] pulses high for 3 cycles -> sw_out unchanged and the debounce counter returns to 0.
3. MANUAL; btn_raw held high for 20 cycles, then low -> exactly one ctrl_out pulse, step_count=1. A second press gives step_count=2.
4. run_raw=1 held for 32 cycles after sync -> ctrl_out pulses every 5 cycles, first at the 5th edge after mode=1, 6 pulses total. Button presses during RUN add no pulses.
5. Collision: arrange the debounced btn rise and an sw_out update on the same edge -> ctrl_out asserts one edge later, and exactly one pulse is issued.
6. Preload step_count to 255 via 255 manual presses, press once more -> step_count=0. Then assert reset with a request pending -> all outputs 0 and no pulse after reset.

Source files
------------

// File: rtl/fsm_step_ctrl.sv
// Front-end for the 2-state Moore core: it synchronises and debounces the switches and the step
// button, and issues one-cycle step pulses that never coincide with a switch-value change.
module fsm_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sw_raw,
    input  logic             btn_raw,
    input  logic             run_raw,
    output logic [1:0]       sw_out,
    output logic             ctrl_out,
    output logic [CNT_W-1:0] step_count,
    output logic             mode
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV);

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic [1:0]            sw_s1, sw_s2;
    logic                  btn_s1, btn_s2;
    logic                  run_s1;
    logic [0:0]            state, next_state;
    logic [2:0]            db_q, db_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  pend_q, pend_d;
    logic                  fire, run_req, man_req, req, sw_chg;
    logic [2:0]            sync_v;

    // The FSM state register doubles as the second synchroniser flop for run_raw.
    assign next_state = run_s1 ? ST_RUN : ST_MANUAL;
    assign sync_v     = {btn_s2, sw_s2};

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync_v[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync_v[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        div_d   = '0;
        run_req = 1'b0;
        if (state == ST_RUN && next_state == ST_RUN) begin
            if (div_q == DIV_W'(RUN_DIV - 1)) begin
                run_req = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    assign man_req = (state == ST_MANUAL) && db_d[2] && !db_q[2];
    assign req     = man_req || run_req;
    assign sw_chg  = (db_d[1:0] != db_q[1:0]);

    // A request that lands on a switch update is deferred; at most one pulse is ever outstanding.
    always_comb begin
        fire   = 1'b0;
        pend_d = pend_q;
        if (pend_q) begin
            if (!sw_chg) begin
                fire   = 1'b1;
                pend_d = 1'b0;
            end
        end else if (req && !ctrl_out) begin
            if (sw_chg) begin
                pend_d = 1'b1;
            end else begin
                fire = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1      <= '0;
            sw_s2      <= '0;
            btn_s1     <= 1'b0;
            btn_s2     <= 1'b0;
            run_s1     <= 1'b0;
            state      <= ST_MANUAL;
            db_q       <= '0;
            db_cnt_q   <= '0;
            div_q      <= '0;
            pend_q     <= 1'b0;
            ctrl_out   <= 1'b0;
            step_count <= '0;
        end else begin
            sw_s1      <= sw_raw;
            sw_s2      <= sw_s1;
            btn_s1     <= btn_raw;
            btn_s2     <= btn_s1;
            run_s1     <= run_raw;
            state      <= next_state;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            ctrl_out   <= fire;
            if (fire) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

    assign sw_out = db_q[1:0];
    assign mode   = (state == ST_RUN);

endmodule
